// File: rtl/pixel_stream_packer.sv
// ============================================================================
// Module      : pixel_stream_packer
// Description : Assigns raster coordinates to incoming pixels and packs
//               PIX_PER_BEAT pixels per beat behind a 2-entry output FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pixel_stream_packer #(
  parameter int COLOUR_WIDTH = 24,
  parameter int PIX_PER_BEAT = 2,
  parameter int COORD_WIDTH  = 16,
  parameter int MAX_WIDTH    = 640,
  parameter int MAX_HEIGHT   = 480
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [COORD_WIDTH-1:0]               cfg_width,
  input  logic [COORD_WIDTH-1:0]               cfg_height,
  input  logic                                 start,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [COLOUR_WIDTH-1:0]              in_colour,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PIX_PER_BEAT*COLOUR_WIDTH-1:0] out_data,
  output logic [COORD_WIDTH-1:0]               out_x,
  output logic [COORD_WIDTH-1:0]               out_y,
  output logic                                 out_sof,
  output logic                                 out_eol,
  output logic                                 out_eof,
  output logic                                 busy,
  output logic                                 cfg_err,
  output logic                                 frame_done,
  output logic [31:0]                          frame_count
);

  localparam int DATA_W = PIX_PER_BEAT * COLOUR_WIDTH;
  localparam logic [COORD_WIDTH-1:0] c_lane_mask  = COORD_WIDTH'(PIX_PER_BEAT - 1);
  localparam logic [COORD_WIDTH-1:0] c_max_width  = COORD_WIDTH'(MAX_WIDTH);
  localparam logic [COORD_WIDTH-1:0] c_max_height = COORD_WIDTH'(MAX_HEIGHT);
  localparam logic [COORD_WIDTH-1:0] c_one        = COORD_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [COORD_WIDTH-1:0] x;
    logic [COORD_WIDTH-1:0] y;
    logic                   sof;
    logic                   eol;
    logic                   eof;
  } beat_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] width_q, width_d;
  logic [COORD_WIDTH-1:0] height_q, height_d;
  logic [COORD_WIDTH-1:0] x_q, x_d;
  logic [COORD_WIDTH-1:0] y_q, y_d;
  logic [DATA_W-1:0]      pack_q, pack_d;
  beat_t                  fifo_q [2];
  beat_t                  fifo_d [2];
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [31:0]            frame_count_q, frame_count_d;

  logic                   cfg_legal;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   last_lane;
  logic                   last_x;
  logic                   last_y;
  logic                   frame_done_w;
  logic [COORD_WIDTH-1:0] lane;
  beat_t                  head;
  beat_t                  new_beat;

  always_comb begin
    cfg_legal = (cfg_width != '0) && (cfg_height != '0) &&
                (cfg_width <= c_max_width) && (cfg_height <= c_max_height) &&
                ((cfg_width & c_lane_mask) == '0);
    accept       = in_valid && in_ready_q;
    head         = fifo_q[rd_ptr_q];
    pop          = (count_q != 2'd0) && out_ready;
    frame_done_w = pop && head.eof;
    lane         = x_q & c_lane_mask;
    last_lane    = (lane == c_lane_mask);
    last_x       = (x_q == width_q - c_one);
    last_y       = (y_q == height_q - c_one);
    push         = accept && last_lane;

    state_d       = state_q;
    width_d       = width_q;
    height_d      = height_q;
    x_d           = x_q;
    y_d           = y_q;
    pack_d        = pack_q;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cfg_err_d     = 1'b0;
    frame_count_d = frame_count_q;

    if (accept) begin
      for (int l = 0; l < PIX_PER_BEAT; l++) begin
        if (lane == COORD_WIDTH'(l)) begin
          pack_d[l*COLOUR_WIDTH +: COLOUR_WIDTH] = in_colour;
        end
      end
      if (last_x) begin
        x_d = '0;
        y_d = y_q + c_one;
      end else begin
        x_d = x_q + c_one;
      end
    end

    // The completing pixel sits in the last lane, so lane 0 is mask positions back.
    new_beat.data = pack_d;
    new_beat.x    = x_q - c_lane_mask;
    new_beat.y    = y_q;
    new_beat.sof  = (new_beat.x == '0) && (y_q == '0);
    new_beat.eol  = last_x;
    new_beat.eof  = last_x && last_y;

    if (push) begin
      fifo_d[wr_ptr_q] = new_beat;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_legal) begin
            state_d  = RUN;
            width_d  = cfg_width;
            height_d = cfg_height;
            x_d      = '0;
            y_d      = '0;
            pack_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept && last_x && last_y) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_done_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_done_w) begin
      frame_count_d = frame_count_q + 32'd1;
    end

    // Looking at the next-cycle count means a full FIFO is never pushed.
    in_ready_d = (state_d == RUN) && (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      width_q       <= '0;
      height_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pack_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      in_ready_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      width_q       <= width_d;
      height_q      <= height_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pack_q        <= pack_d;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      cfg_err_q     <= cfg_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_data    = head.data;
  assign out_x       = head.x;
  assign out_y       = head.y;
  assign out_sof     = head.sof;
  assign out_eol     = head.eol;
  assign out_eof     = head.eof;
  assign busy        = (state_q != IDLE);
  assign cfg_err     = cfg_err_q;
  assign frame_done  = frame_done_w;
  assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: doc/pixel_stream_packer.md
Name: pixel_stream_packer

Overview:
- Parametrised successor to the single-pixel coordinate/colour combinator in the video output path.
- Accepts one pixel colour per handshake from the pixel generator and assigns raster coordinates.
- Packs PIX_PER_BEAT pixels into one output beat and emits start-of-frame, end-of-line and end-of-frame flags.
- Supports a runtime-programmable resolution and full valid/ready backpressure through a 2-entry output buffer.

Parameters:
- COLOUR_WIDTH, 24, bits per pixel colour.
- PIX_PER_BEAT, 2, pixels packed per output beat; power of two, 1..8.
- COORD_WIDTH, 16, width of coordinate and configuration fields.
- MAX_WIDTH, 640, largest legal cfg_width.
- MAX_HEIGHT, 480, largest legal cfg_height.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- cfg_width  in  COORD_WIDTH  pixels per line; sampled on start.
- cfg_height  in  COORD_WIDTH  lines per frame; sampled on start.
- start  in  1  single-cycle pulse that begins one frame.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_colour  in  COLOUR_WIDTH  pixel colour.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  PIX_PER_BEAT*COLOUR_WIDTH  packed colours; lane 0 (lowest x) in bits [COLOUR_WIDTH-1:0].
- out_x  out  COORD_WIDTH  x of lane 0 pixel.
- out_y  out  COORD_WIDTH  y of beat.
- out_sof  out  1  first beat of frame.
- out_eol  out  1  last beat of a line.
- out_eof  out  1  last beat of frame (out_eol also 1).
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse on a rejected start.
- frame_done  out  1  one-cycle pulse when the eof beat handshakes.
- frame_count  out  32  completed frames; wraps modulo 2^32.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values: all outputs 0, including in_ready, out_valid and frame_count. State = IDLE. x/y/lane counters, partial beat and buffer are cleared. Reset mid-frame discards all in-flight data; no flags are emitted.
- States: IDLE, RUN, DRAIN.
- IDLE + start:
  - cfg is legal when width != 0, height != 0, width <= MAX_WIDTH, height <= MAX_HEIGHT, and width % PIX_PER_BEAT == 0.
  - Legal cfg: latch cfg, zero counters, go to RUN the next cycle.
  - Illegal cfg: cfg_err = 1 for one cycle; stay in IDLE.
- start outside IDLE is ignored. Changes to cfg_* after latching have no effect until the next start.
- in_ready = (state == RUN) && (buffer count < 2), registered. Using a registered count is acceptable, provided no accepted pixel is ever lost.
- Pixel accepted when in_valid && in_ready:
  - The pixel is written to lane = x % PIX_PER_BEAT.
  - x increments. At x == width-1, x wraps to 0 and y increments.
- Beat push: when the last lane is written, the beat pushes into the buffer with:
  - out_x = x of lane 0.
  - sof = (x_lane0 == 0 && y == 0).
  - eol = (last x of line).
  - eof = eol && (y == height-1).
- Latency: the pixel completing a beat is visible on out_valid the next cycle, if the buffer was empty.
- On the eof pixel: in_ready deasserts the next cycle and the state goes to DRAIN. DRAIN returns to IDLE on the cycle the eof beat handshakes (out_valid && out_ready). frame_done pulses in that same cycle and frame_count increments.
- Output buffer: 2-entry FIFO.
  - out_* held stable while out_valid && !out_ready.
  - Simultaneous push and pop on a 1-entry buffer keeps count = 1.
  - No push occurs when full; guaranteed by in_ready.
- PIX_PER_BEAT = 1: every accepted pixel produces one beat; otherwise identical.
- in_valid while in_ready = 0 has no effect; in_colour is don't-care.

Test Plan:
1. Basic frame: PIX_PER_BEAT=2, width=4, height=2, start, in_valid held 1, out_ready held 1, colours 1..8.
   - Required: 4 beats, with out_data lanes {1,2},{3,4},{5,6},{7,8}.
   - Required: out_x 0,2,0,2 and out_y 0,0,1,1.
   - Required: sof on beat 0 only; eol on beats 1 and 3; eof on beat 3.
   - Required: frame_done once, frame_count = 1, busy low afterwards.
2. Backpressure: same config, out_ready held 0.
   - Required: exactly 4 pixels accepted (2 beats buffered), then in_ready = 0 and out_* stable.
   - Release out_ready -> required: remaining beats in order, with no loss or duplication.
3. Illegal config: start with width=5 (PIX_PER_BEAT=2), then width=0, then height=481.
   - Required: cfg_err pulses each time, busy stays 0, and no out_valid.
4. Reset mid-frame: reset after 3 pixels of a width=4, height=2 frame.
   - Required: all outputs 0 the next cycle and no stale beat afterwards.
   - New start -> required: a clean frame identical to test 1.
5. Gapped input: in_valid toggled randomly, out_ready toggled randomly, width=640, height=480.
   - Required: 153600 beats with correct coordinates and flags.
   - Required: exactly one sof and one eof, and 480 eol.
6. Start ignored: start pulsed again while RUN.
   - Required: no counter or cfg change; the frame completes normally.
